jtframe_pocket_upload: RTL

// Read-back (upload) path for the Pocket bridge. It serves 32-bit bridge reads from
// the core's byte-wide ioctl memory, such as NVRAM saves. Each word is assembled from
// 4 sequential ioctl byte reads, and a one-word prefetch speeds up sequential bursts.

---
 rtl/jtframe_pocket_pkg.sv | 26 ++
 rtl/jtframe_pocket_wordfetch.sv | 71 +++++++
 rtl/jtframe_pocket_upload.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/jtframe_pocket_pkg.sv
//------------------------------------------------------------------------------
// jtframe_pocket_pkg
// Shared encodings and bridge window constants for the Pocket base.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package jtframe_pocket_pkg;

  typedef logic [22:0] word_addr_t;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DFETCH = 2'd1;
  localparam logic [1:0] PFETCH = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  localparam logic [7:0] UPLOAD_WIN = 8'h00;
  localparam logic [7:0] CTRL_WIN   = 8'hF8;

  function automatic logic in_window(input logic [31:0] addr, input logic [7:0] win);
    return addr[31:24] == win;
  endfunction

endpackage

`default_nettype wire

// File: rtl/jtframe_pocket_wordfetch.sv
//------------------------------------------------------------------------------
// jtframe_pocket_wordfetch
// Assembles one 32-bit word from four sequential ioctl byte reads.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module jtframe_pocket_wordfetch
  import jtframe_pocket_pkg::*;
#(
  parameter int DIN_LAT = 2
) (
  input  logic        clk_rom,
  input  logic        rst,
  input  logic        start,
  input  word_addr_t  wa,
  input  logic        abort,
  input  logic [7:0]  ioctl_din,
  output logic [31:0] word,
  output logic        done,
  output logic [24:0] ioctl_addr
);

  localparam int LAT_W = (DIN_LAT < 1) ? 1 : $clog2(DIN_LAT + 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(DIN_LAT);

  logic             active;
  word_addr_t       cur_wa;
  logic [1:0]       byte_idx;
  logic [LAT_W-1:0] lat;
  logic [23:0]      low_bytes;

  // The top byte is taken straight from ioctl_din so the word is usable on the done cycle.
  assign done       = active && (lat == LAT_LAST) && (byte_idx == 2'd3);
  assign word       = {ioctl_din, low_bytes};
  assign ioctl_addr = {cur_wa, byte_idx};

  always_ff @(posedge clk_rom) begin
    if (rst) begin
      active    <= 1'b0;
      cur_wa    <= '0;
      byte_idx  <= 2'd0;
      lat       <= '0;
      low_bytes <= '0;
    end else if (start) begin
      active   <= 1'b1;
      cur_wa   <= wa;
      byte_idx <= 2'd0;
      lat      <= '0;
    end else if (abort) begin
      active <= 1'b0;
    end else if (active) begin
      if (lat == LAT_LAST) begin
        lat <= '0;
        case (byte_idx)
          2'd0:    low_bytes[7:0]   <= ioctl_din;
          2'd1:    low_bytes[15:8]  <= ioctl_din;
          2'd2:    low_bytes[23:16] <= ioctl_din;
          default: ;
        endcase
        if (byte_idx == 2'd3) active   <= 1'b0;
        else                  byte_idx <= byte_idx + 2'd1;
      end else begin
        lat <= lat + LAT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/jtframe_pocket_upload.sv
//------------------------------------------------------------------------------
// jtframe_pocket_upload
// Bridge read-back path: serves 32-bit reads from byte-wide ioctl memory with prefetch.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module jtframe_pocket_upload
  import jtframe_pocket_pkg::*;
#(
  parameter int         DIN_LAT  = 2,
  parameter logic [7:0] WIN      = UPLOAD_WIN,
  parameter bit         PREFETCH = 1'b1
) (
  input  logic        clk_rom,
  input  logic        rst,
  input  logic        slot_en,
  input  logic        rd,
  input  logic [31:0] rd_addr,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        busy,
  output logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_din,
  output logic        ioctl_ram,
  output logic        uploading
);

  logic [1:0]  state;
  logic        pf_valid;
  word_addr_t  pf_wa;
  word_addr_t  dem_wa;
  logic [31:0] pf_word;

  word_addr_t  wa;
  logic        accept;
  logic        hit;
  logic        pf_next;
  logic        f_start;
  logic        f_abort;
  word_addr_t  f_wa;
  logic [31:0] f_word;
  logic        f_done;
  logic        unused_lsb;

  assign wa         = rd_addr[24:2];
  assign unused_lsb = ^rd_addr[1:0];
  assign accept     = rd && slot_en && in_window(rd_addr, WIN);
  assign hit        = pf_valid && (pf_wa == wa);
  // The last word of the space has no successor: no wrap-around prefetch.
  assign pf_next    = PREFETCH && (dem_wa != '1);
  assign busy       = (state == DFETCH);
  assign ioctl_ram  = (state == DFETCH) || (state == PFETCH);

  always_comb begin
    f_start = 1'b0;
    f_abort = 1'b0;
    f_wa    = wa;
    if (!slot_en) begin
      f_abort = 1'b1;
    end else begin
      case (state)
        IDLE:    f_start = accept && !hit;
        PFETCH:  f_start = accept && (wa != pf_wa);
        RESP: begin
          f_start = pf_next;
          f_wa    = dem_wa + 23'd1;
        end
        default: ;
      endcase
    end
  end

  jtframe_pocket_wordfetch #(
    .DIN_LAT (DIN_LAT)
  ) u_wordfetch (
    .clk_rom    (clk_rom),
    .rst        (rst),
    .start      (f_start),
    .wa         (f_wa),
    .abort      (f_abort),
    .ioctl_din  (ioctl_din),
    .word       (f_word),
    .done       (f_done),
    .ioctl_addr (ioctl_addr)
  );

  always_ff @(posedge clk_rom) begin
    if (rst) begin
      state     <= IDLE;
      pf_valid  <= 1'b0;
      pf_wa     <= '0;
      dem_wa    <= '0;
      pf_word   <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      uploading <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (!slot_en) begin
        state     <= IDLE;
        pf_valid  <= 1'b0;
        uploading <= 1'b0;
      end else begin
        if (accept) uploading <= 1'b1;
        case (state)
          IDLE: if (accept) begin
            dem_wa   <= wa;
            pf_valid <= 1'b0;
            if (hit) begin
              rd_data  <= pf_word;
              rd_valid <= 1'b1;
              state    <= RESP;
            end else begin
              state <= DFETCH;
            end
          end
          DFETCH: if (f_done) begin
            rd_data  <= f_word;
            rd_valid <= 1'b1;
            state    <= RESP;
          end
          RESP: begin
            if (pf_next) begin
              pf_wa <= dem_wa + 23'd1;
              state <= PFETCH;
            end else begin
              state <= IDLE;
            end
          end
          PFETCH: begin
            if (accept) begin
              // A matching read takes over the running fetch without losing progress.
              dem_wa <= wa;
              if ((wa == pf_wa) && f_done) begin
                rd_data  <= f_word;
                rd_valid <= 1'b1;
                state    <= RESP;
              end else begin
                state <= DFETCH;
              end
            end else if (f_done) begin
              pf_word  <= f_word;
              pf_valid <= 1'b1;
              state    <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire
